// File: rtl/int_accept_pkg.sv
// rtl/int_accept_pkg.sv - shared state encoding, cause-word layout and address default for int_accept_ctrl
package int_accept_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_CLR_RD = 3'd3,
    ST_CLR_WR = 3'd4
  } state_e;

  localparam logic [31:0] PEND_ADDR_DEFAULT = 32'h0000_0024;
  localparam int          CAUSE_ID_W        = 8;

  // mcause layout: interrupt flag in bit 31, source ID in the low byte
  function automatic logic [31:0] make_cause(input logic msb, input logic [CAUSE_ID_W-1:0] id);
    return {msb, 23'b0, id};
  endfunction

endpackage

// File: rtl/int_sync2.sv
// rtl/int_sync2.sv - two-flop synchronizer used when INT_ACCEPT_SYNC_EN is defined
module int_sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/int_accept_ctrl.sv
// rtl/int_accept_ctrl.sv - interrupt accept/return controller; INT_ACCEPT_SYNC_EN adds an input synchronizer
module int_accept_ctrl
  import int_accept_pkg::*;
#(
  parameter logic [31:0] PEND_ADDR = PEND_ADDR_DEFAULT,
  parameter logic        CAUSE_MSB = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        irq_i,
  input  logic [7:0]  irq_id_i,
  input  logic        mie_i,
  output logic        int_req_o,
  input  logic        int_ack_i,
  output logic [31:0] int_cause_o,
  input  logic        mret_i,
  output logic        busy_o,
  output logic        spurious_o,
  output logic        reg_re_o,
  output logic        reg_we_o,
  output logic [31:0] reg_addr_o,
  output logic [31:0] reg_wdata_o,
  output logic [3:0]  reg_be_o,
  input  logic [31:0] reg_rdata_i
);

  logic       irq_s;
  logic [7:0] irq_id_s;

`ifdef INT_ACCEPT_SYNC_EN
  int_sync2 #(.W(9)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   ({irq_i, irq_id_i}),
    .q_o   ({irq_s, irq_id_s})
  );
`else
  assign irq_s    = irq_i;
  assign irq_id_s = irq_id_i;
`endif

  state_e      state_q, state_d;
  logic [7:0]  id_q, id_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] data_q, data_d;
  logic        spur_q, spur_d;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cause_d = cause_q;
    data_d  = data_q;
    spur_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (irq_s && mie_i) begin
          state_d = ST_REQ;
          id_d    = irq_id_s;
          cause_d = make_cause(CAUSE_MSB, irq_id_s);
        end
      end
      // ack wins over a simultaneous withdrawal
      ST_REQ: begin
        if (int_ack_i)   state_d = ST_ACTIVE;
        else if (!irq_s) state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (mret_i) begin
          if (id_q[7:5] != 3'b0) begin
            state_d = ST_IDLE;
            spur_d  = 1'b1;
          end else begin
            state_d = ST_CLR_RD;
          end
        end
      end
      ST_CLR_RD: begin
        data_d  = reg_rdata_i;
        state_d = ST_CLR_WR;
      end
      ST_CLR_WR: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      cause_q <= '0;
      data_q  <= '0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cause_q <= cause_d;
      data_q  <= data_d;
      spur_q  <= spur_d;
    end
  end

  logic bus_rd, bus_wr;
  assign bus_rd = (state_q == ST_CLR_RD);
  assign bus_wr = (state_q == ST_CLR_WR);

  assign int_req_o   = (state_q == ST_REQ);
  assign busy_o      = (state_q == ST_ACTIVE) || bus_rd || bus_wr;
  assign int_cause_o = cause_q;
  assign spurious_o  = spur_q;
  assign reg_re_o    = bus_rd;
  assign reg_we_o    = bus_wr;
  assign reg_addr_o  = (bus_rd || bus_wr) ? PEND_ADDR : 32'h0;
  assign reg_be_o    = (bus_rd || bus_wr) ? 4'hF : 4'h0;
  assign reg_wdata_o = bus_wr ? (data_q & ~(32'd1 << id_q[4:0])) : 32'h0;

endmodule
